// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: the loader FSM state encoding,
// the default response bytes sent to the host, and the word width in bytes.
// -----------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_DATA,
      ST_RESP,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [7:0] DEF_ACK_BYTE = 8'hAA;
   localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;
   localparam int         WORD_BYTES   = 4;

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles a 32-bit little-endian word from a byte stream. Each accepted byte
// shifts in from the top, so after four bytes the register holds
// {b3,b2,b1,b0}. The byte index wraps 3 -> 0.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   en_i         in   accept byte_i this cycle
//   byte_i       in   incoming byte
//   word_o       out  assembled word, meaningful while word_valid_o is high
//   word_valid_o out  high in the cycle the 4th byte of a word is accepted
//   idx_o        out  number of bytes of the current word already accepted
// -----------------------------------------------------------------------------
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o,
   output logic [1:0]  idx_o
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [31:0] shift_q, shift_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (en_i) begin
         shift_d = {byte_i, shift_q[31:8]};
         idx_d   = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   // The completed word is presented combinationally alongside the strobe so
   // the consumer can register it in the same cycle the last byte arrives.
   assign word_o       = {byte_i, shift_q[31:8]};
   assign word_valid_o = en_i && (idx_q == LAST_IDX);
   assign idx_o        = idx_q;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a program image over a UART byte stream (4-byte LE word count N,
// then N LE words) and writes each word into instruction memory. Word k is
// written at byte address 4*(k+1). On completion an acknowledge byte (or an
// error byte for an oversized header) is offered to the UART transmitter, and
// the loader parks in DONE or ERR until reset.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   pro_data   out  word to write
//   pro_addr   out  byte address of the write
//   memwrite   out  one-cycle write strobe
//   tx_data    out  response byte
//   tx_valid   out  response valid, held until tx_ready
//   tx_ready   in   transmitter accepts tx_data
//   busy       out  load in progress
//   load_done  out  sticky: load finished successfully
//   load_err   out  sticky: header rejected
// -----------------------------------------------------------------------------
module program_loader
   import loader_pkg::*;
#(
   parameter int         MAX_WORDS = 64,
   parameter logic [7:0] ACK_BYTE  = DEF_ACK_BYTE,
   parameter logic [7:0] ERR_BYTE  = DEF_ERR_BYTE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] pro_data,
   output logic [31:0] pro_addr,
   output logic        memwrite,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        load_done,
   output logic        load_err
);

   localparam int KW = $clog2(MAX_WORDS + 1);

   state_e         state_q, state_d;
   logic [31:0]    n_q, n_d;
   logic [KW-1:0]  k_q, k_d;
   logic [KW-1:0]  k_inc;
   logic [31:0]    pro_data_q, pro_data_d;
   logic [31:0]    pro_addr_q, pro_addr_d;
   logic           memwrite_q, memwrite_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           err_q, err_d;

   logic           packer_en;
   logic [31:0]    packed_word;
   logic           word_valid;
   logic [1:0]     byte_idx;

   // Bytes arriving while responding or parked are dropped, never assembled.
   assign packer_en = rx_valid && ((state_q == ST_HDR) || (state_q == ST_DATA));

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .en_i         (packer_en),
      .byte_i       (rx_data),
      .word_o       (packed_word),
      .word_valid_o (word_valid),
      .idx_o        (byte_idx)
   );

   assign k_inc = k_q + KW'(1);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      k_d        = k_q;
      pro_data_d = pro_data_q;
      pro_addr_d = pro_addr_q;
      memwrite_d = 1'b0;
      tx_data_d  = tx_data_q;
      err_d      = err_q;

      case (state_q)
         ST_HDR: begin
            if (word_valid) begin
               n_d = packed_word;
               k_d = '0;
               if (packed_word == 32'd0) begin
                  tx_data_d = ACK_BYTE;
                  state_d   = ST_RESP;
               end else if (packed_word > 32'(MAX_WORDS)) begin
                  tx_data_d = ERR_BYTE;
                  err_d     = 1'b1;
                  state_d   = ST_RESP;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_valid) begin
               pro_data_d = packed_word;
               // Memory stores at index pro_addr[7:2]-1, hence the +1 offset.
               pro_addr_d = 32'({k_inc, 2'b00});
               memwrite_d = 1'b1;
               k_d        = k_inc;
               if (32'(k_inc) == n_q) begin
                  tx_data_d = ACK_BYTE;
                  state_d   = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (tx_ready) begin
               state_d = err_q ? ST_ERR : ST_DONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HDR;
         n_q        <= '0;
         k_q        <= '0;
         pro_data_q <= '0;
         pro_addr_q <= '0;
         memwrite_q <= 1'b0;
         tx_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         k_q        <= k_d;
         pro_data_q <= pro_data_d;
         pro_addr_q <= pro_addr_d;
         memwrite_q <= memwrite_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
      end
   end

   assign pro_data  = pro_data_q;
   assign pro_addr  = pro_addr_q;
   assign memwrite  = memwrite_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = (state_q == ST_RESP);
   assign load_done = (state_q == ST_DONE);
   assign load_err  = (state_q == ST_ERR);
   // In HDR the loader counts as busy once part of the header has arrived.
   assign busy      = (state_q == ST_DATA) || (state_q == ST_RESP) ||
                      ((state_q == ST_HDR) && (byte_idx != 2'd0));

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [31:0] pro_data;
   logic [31:0] pro_addr;
   logic        memwrite;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        load_done;
   logic        load_err;

   program_loader dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .pro_data  (pro_data),
      .pro_addr  (pro_addr),
      .memwrite  (memwrite),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .load_done (load_done),
      .load_err  (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int tx_seen  = 0;

   // Model state: expected writes and response for the current stream.
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [7:0]  exp_resp;
   logic        exp_err;
   // Observed writes for literal pinning and spacing checks.
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          wr_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Behavioural model: decode the stream into the list of writes it implies.
   task automatic model_load(input bq_t b);
      logic [31:0] n;
      exp_addr.delete();
      exp_data.delete();
      n = {b[3], b[2], b[1], b[0]};
      exp_err  = 1'b0;
      exp_resp = 8'hAA;
      if (n > 32'd64) begin
         exp_err  = 1'b1;
         exp_resp = 8'hEE;
      end else begin
         for (int k = 0; k < int'(n); k++) begin
            exp_addr.push_back(32'(4 * (k + 1)));
            exp_data.push_back({b[4+4*k+3], b[4+4*k+2], b[4+4*k+1], b[4+4*k]});
         end
      end
   endtask

   // Single compare process for every cycle outputs are meaningful.
   always @(negedge clk) begin
      if (!rst) begin
         if (memwrite) begin
            $display("WRITE cyc=%0d addr=%h data=%h", cyc, pro_addr, pro_data);
            checks++;
            if (exp_addr.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write actual=%h required=none", pro_addr);
            end else begin
               logic [31:0] ea, ed;
               ea = exp_addr.pop_front();
               ed = exp_data.pop_front();
               if (pro_addr !== ea || pro_data !== ed) begin
                  failures++;
                  $display("FAIL write actual=%h/%h required=%h/%h", pro_addr, pro_data, ea, ed);
               end
            end
            obs_addr.push_back(pro_addr);
            obs_data.push_back(pro_data);
            wr_cyc.push_back(cyc);
         end
         if (tx_valid) begin
            tx_seen++;
            checks++;
            if (tx_data !== exp_resp) begin
               failures++;
               $display("FAIL tx_data actual=%h required=%h", tx_data, exp_resp);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pro_data"},  pro_data, 32'h0);
      chk({tag, "_pro_addr"},  pro_addr, 32'h0);
      chk({tag, "_memwrite"},  32'(memwrite), 32'h0);
      chk({tag, "_tx_data"},   32'(tx_data), 32'h0);
      chk({tag, "_tx_valid"},  32'(tx_valid), 32'h0);
      chk({tag, "_busy"},      32'(busy), 32'h0);
      chk({tag, "_load_done"}, 32'(load_done), 32'h0);
      chk({tag, "_load_err"},  32'(load_err), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      obs_addr.delete();
      obs_data.delete();
      wr_cyc.delete();
      @(negedge clk);
   endtask

   // Called just after a negedge; returns just after a negedge.
   task automatic send(input bq_t q, input bit full_rate);
      foreach (q[i]) begin
         rx_data  = q[i];
         rx_valid = 1'b1;
         @(negedge clk);
         if (!full_rate) begin
            rx_valid = 1'b0;
            @(negedge clk);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic finish_resp(input int hold, input logic done_req, input logic err_req);
      int t;
      logic [7:0] held;
      t = 0;
      while (!tx_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!tx_valid) begin
         failures++;
         $display("FAIL resp_timeout actual=no_tx_valid required=tx_valid");
         return;
      end
      $display("RESP cyc=%0d tx_data=%h", cyc, tx_data);
      held = tx_data;
      for (int i = 0; i < hold; i++) begin
         chk("tx_hold_valid", 32'(tx_valid), 32'h1);
         chk("tx_hold_data", 32'(tx_data), 32'(held));
         @(negedge clk);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("tx_valid_drop", 32'(tx_valid), 32'h0);
      chk("load_done", 32'(load_done), 32'(done_req));
      chk("load_err", 32'(load_err), 32'(err_req));
      chk("busy_idle", 32'(busy), 32'h0);
      chk("writes_pending", 32'(exp_addr.size()), 32'h0);
   endtask

   initial begin
      bq_t s;
      int  tx_before;
      rst      = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      #2;

      // Test 1: N=2 normal load
      do_reset();
      s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
            8'hEF, 8'h00, 8'h80, 8'h00};
      model_load(s);
      send('{8'h02}, 1'b0);
      chk("busy_after_hdr0", 32'(busy), 32'h1);
      send(s[1:$], 1'b0);
      finish_resp(0, 1'b1, 1'b0);
      chk("t1_nwrites", 32'(obs_addr.size()), 32'd2);
      chk("t1_addr0", obs_addr[0], 32'h4);
      chk("t1_data0", obs_data[0], 32'h00500113);
      chk("t1_addr1", obs_addr[1], 32'h8);
      chk("t1_data1", obs_data[1], 32'h008000EF);

      // Test 2: N=0
      do_reset();
      s = '{8'h00, 8'h00, 8'h00, 8'h00};
      model_load(s);
      send(s, 1'b0);
      finish_resp(0, 1'b1, 1'b0);
      chk("t2_nwrites", 32'(obs_addr.size()), 32'd0);

      // Test 3: N=65 header error, trailing bytes dropped
      do_reset();
      s = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88};
      model_load(s);
      send(s, 1'b0);
      finish_resp(0, 1'b0, 1'b1);
      chk("t3_nwrites", 32'(obs_addr.size()), 32'd0);
      chk("t3_resp_lit", 32'(exp_resp), 32'hEE);

      // Test 4: full-rate N=3, tx_ready held low 10 cycles
      do_reset();
      s = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hFF, 8'hEE, 8'hDD, 8'hCC};
      model_load(s);
      send(s, 1'b1);
      finish_resp(10, 1'b1, 1'b0);
      chk("t4_nwrites", 32'(wr_cyc.size()), 32'd3);
      chk("t4_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
      chk("t4_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
      chk("t4_addr2", obs_addr[2], 32'hC);
      chk("t4_data0", obs_data[0], 32'h04030201);

      // Test 5: reset after 6 bytes, then fresh N=1
      do_reset();
      exp_addr.delete();
      exp_data.delete();
      send('{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01}, 1'b0);
      chk("t5_busy_mid", 32'(busy), 32'h1);
      do_reset();
      s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      model_load(s);
      send(s, 1'b0);
      finish_resp(0, 1'b1, 1'b0);
      chk("t5_nwrites", 32'(obs_addr.size()), 32'd1);
      chk("t5_addr0", obs_addr[0], 32'h4);
      chk("t5_data0", obs_data[0], 32'h12345678);

      // Test 6: extra bytes after DONE are ignored
      tx_before = tx_seen;
      send('{8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b1);
      repeat (3) @(negedge clk);
      chk("t6_no_tx", 32'(tx_seen), 32'(tx_before));
      chk("t6_nwrites", 32'(obs_addr.size()), 32'd1);
      chk("t6_done", 32'(load_done), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Receives a program image as a byte stream from the UART receiver and writes it, one 32-bit word at a time, into the instruction memory over the `pro_data`/`pro_addr`/`memwrite` write port. It sits directly upstream of the instruction memory and is active only before the core is released. Completion is signalled to the core and to the host with an acknowledge byte on the UART transmitter.

## Interface
Parameters:
- `MAX_WORDS`, default 64: capacity of the instruction memory in words. A header count above this value is an error.
- `ACK_BYTE`, default 8'hAA: byte sent to the host on successful completion.
- `ERR_BYTE`, default 8'hEE: byte sent to the host on a header error.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe marking `rx_data` valid. Back-to-back strobes are allowed.
- `pro_data`, out, 32: word to write.
- `pro_addr`, out, 32: byte address of the write.
- `memwrite`, out, 1: one-cycle write strobe.
- `tx_data`, out, 8: response byte.
- `tx_valid`, out, 1: response valid; held until accepted.
- `tx_ready`, in, 1: transmitter accepts `tx_data` when `tx_valid && tx_ready`.
- `busy`, out, 1: high from the first header byte until DONE or ERR.
- `load_done`, out, 1: sticky high after a successful load; releases the core.
- `load_err`, out, 1: sticky high after a header error.

## Operation
- Stream format: a 4-byte little-endian word count N, followed by N words, each 4 bytes little-endian.
- States:
  - HDR: collects 4 bytes into N. On the 4th byte:
    - N == 0: go to RESP with `ACK_BYTE`.
    - N > MAX_WORDS: go to RESP with `ERR_BYTE` and set an error flag.
    - Otherwise: go to DATA.
  - DATA: collects bytes into a shift register; the byte index wraps 3→0. On every 4th byte:
    - Register `pro_data`, `pro_addr`, and `memwrite`=1 for the next cycle.
    - Increment word index k.
    - After word N−1, go to RESP with `ACK_BYTE`.
  - RESP: `tx_valid`=1 with the selected byte. When `tx_ready` is sampled high, go to DONE, or to ERR if the error flag is set.
  - DONE: `load_done`=1. Terminal until `rst`.
  - ERR: `load_err`=1. Terminal until `rst`.
- Address rule: the instruction memory stores at word index `pro_addr[7:2]`−1, so word k is emitted with `pro_addr` = 4·(k+1), zero-extended to 32 bits. Word 0 therefore uses address 4 and lands at index 0.
- Byte packing: `pro_data` = {b3,b2,b1,b0}, where b0 is the first byte of the word.
- `rx_valid` is ignored in RESP, DONE and ERR; those bytes are dropped.
- `busy` = (state is DATA or RESP) or (state is HDR and at least one header byte has been received).

## Timing
- Reset values: state HDR; all counters 0; `pro_data`=0, `pro_addr`=0, `memwrite`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `load_done`=0, `load_err`=0.
- Write latency: `memwrite` is high exactly one cycle, in the cycle after the `rx_valid` that carried b3.
- `pro_data` and `pro_addr` are valid in that cycle and hold their values until the next write.
- Back-to-back `rx_valid` at full rate: each word still produces one strobe. Strobes are at least 4 cycles apart.
- RESP is entered in the cycle after the last b3, so the final `memwrite` and the first `tx_valid` cycle coincide.
- `tx_valid` holds with `tx_data` stable until the handshake. It drops in the cycle after `tx_ready` is sampled high.
- `load_done` or `load_err` rises in that same cycle.
- Reset mid-load: all state clears immediately. Words already written stay in memory, and the next byte is treated as header byte 0.
- Counter widths:
  - N register: 32 bits.
  - Word index k: $clog2(MAX_WORDS+1) bits; cannot overflow because N ≤ MAX_WORDS is enforced.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum (HDR, DATA, RESP, DONE, ERR);
  - `ACK_BYTE` and `ERR_BYTE` default constants;
  - the localparam `WORD_BYTES`=4.
- One sub-module, `byte_packer`. It is a 4-byte little-endian shift/assemble register with a 2-bit byte index and a `word_valid` pulse on the 4th byte. It is shared by header collection and data collection.
- The FSM, address generation and response logic live in `program_loader`.

## Test plan
- N=2, bytes 02 00 00 00 / 13 01 50 00 / EF 00 80 00:
  - `memwrite` pulses twice: `pro_addr`=4 with `pro_data`=32'h00500113, then `pro_addr`=8 with `pro_data`=32'h008000EF.
  - `tx_data`=8'hAA, then `load_done`=1.
- N=0 (00 00 00 00): no `memwrite`; ACK sent; `load_done`=1.
- N=65 (41 00 00 00):
  - Following bytes produce no `memwrite`.
  - `tx_data`=8'hEE; `load_err`=1; `load_done` stays 0.
- Full-rate `rx_valid` for N=3 with `tx_ready` held low 10 cycles:
  - Three write strobes spaced exactly 4 cycles apart at addresses 4, 8, 12.
  - `tx_valid` holds 10 cycles with `tx_data` stable, then drops one cycle after `tx_ready` rises.
- `rst` asserted after 6 bytes of an N=2 load:
  - All outputs return to reset values the same cycle.
  - A fresh N=1 stream then writes `pro_addr`=4 and completes.
- Extra bytes after DONE: no `memwrite`, no `tx_valid`; `load_done` stays 1.
